muldiv_hilo_ctrl: RTL and testbench

- Sequencer for MULT/MULTU/DIV/DIVU. Owns the architectural HI and LO registers that EX reads through its HI/LO inputs.
- Runs an iterative 32-step shift-add multiplier or restoring divider on the EX operands (RD1, RD2).
- Asserts a stall to the pipeline when a dependent instruction arrives while an operation is in flight.
- Handles MTHI/MTLO writes and flush/abort.

---
 rtl/muldiv_hilo_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns the
// architectural HI/LO registers, with pipeline stall, MTHI/MTLO and flush.
// Optional build macro MULDIV_DIV0_FAST_EN adds a div0 output and a short
// path that skips the iteration phase on divide-by-zero.
module muldiv_hilo_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic             hilo_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             stall,
    output logic             done
`ifdef MULDIV_DIV0_FAST_EN
    ,
    output logic             div0
`endif
);

    localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIX
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] mcand_q;   // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0] acc_hi_q;  // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo_q;  // multiplier being consumed / dividend-quotient
    logic             neg_q, rneg_q, div0_q;
    logic [CW-1:0]    cnt_q;

    logic             signed_op, is_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             accept;

    assign accept    = start && !flush;
    assign signed_op = ~op_q[0];
    assign is_div    = op_q[1];

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic and pipeline handshake outputs
    always_comb begin
        state_d = state_q;
        busy    = (state_q != S_IDLE);
        stall   = busy && (start || mthi_we || mtlo_we || hilo_rd);
        done    = (state_q == S_FIX) && !flush;
        case (state_q)
            S_IDLE: if (accept) state_d = S_PREP;
            S_PREP: begin
                if (flush) state_d = S_IDLE;
`ifdef MULDIV_DIV0_FAST_EN
                else if (is_div && (b_q == '0)) state_d = S_FIX;
`endif
                else state_d = S_CALC;
            end
            S_CALC: begin
                if (flush) state_d = S_IDLE;
                else if (cnt_q == CW'(STEPS - 1)) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MULDIV_DIV0_FAST_EN
    assign div0 = done && div0_q;
`endif

    // Operand magnitudes, one iteration step, and sign-corrected results
    always_comb begin
        mag_a     = (signed_op && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
        mag_b     = (signed_op && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand_q});
        // Only the low bits matter: when the subtraction is taken the true
        // difference is already below the divisor.
        div_diff  = div_shift[WIDTH-1:0] - mcand_q;
        if (is_div) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_q ? ('0 - prod) : prod;
        if (!is_div) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = a_q;
            res_lo = '1;
        end else begin
            res_hi = rneg_q ? ('0 - acc_hi_q) : acc_hi_q;
            res_lo = neg_q  ? ('0 - acc_lo_q) : acc_lo_q;
        end
    end

    // Operand capture, sign preparation and iterative datapath
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        a_q  <= RD1;
                        b_q  <= RD2;
                    end
                end
                S_PREP: begin
                    neg_q    <= signed_op && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rneg_q   <= signed_op && a_q[WIDTH-1];
                    div0_q   <= is_div && (b_q == '0);
                    acc_hi_q <= '0;
                    acc_lo_q <= is_div ? mag_a : mag_b;
                    mcand_q  <= is_div ? mag_b : mag_a;
                    cnt_q    <= '0;
                end
                S_CALC: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Architectural HI/LO: op results in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            HI <= '0;
            LO <= '0;
        end else if (state_q == S_FIX) begin
            if (!flush) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end else if (state_q == S_IDLE && !start) begin
            if (mthi_we) HI <= RD1;
            if (mtlo_we) LO <= RD1;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl (default build, 32-bit).
module tb_muldiv_hilo_ctrl;

    localparam int STEPS = 32;

    logic        clk_in  = 1'b0;
    logic        rst_in  = 1'b1;
    logic        start   = 1'b0;
    logic [1:0]  op      = 2'd0;
    logic [31:0] RD1     = '0;
    logic [31:0] RD2     = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        flush   = 1'b0;
    logic [31:0] HI, LO;
    logic        busy, stall, done;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_hilo_ctrl #(.WIDTH(32), .STEPS(STEPS)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (start),
        .op     (op),
        .RD1    (RD1),
        .RD2    (RD2),
        .mthi_we(mthi_we),
        .mtlo_we(mtlo_we),
        .hilo_rd(hilo_rd),
        .flush  (flush),
        .HI     (HI),
        .LO     (LO),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
    );

    always #5 clk_in = ~clk_in;

    // Architectural result {HI,LO} of a mul/div operation.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'd0: begin p = sa * sb; return p; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (o == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            4: return 32'h0 - $urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        total++; if (HI !== 32'h0)   begin bad++; $display("FAIL reset_hi: got %h want 0", HI); end
        total++; if (LO !== 32'h0)   begin bad++; $display("FAIL reset_lo: got %h want 0", LO); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_in = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk_in);
    endtask

    // Issue one op and check busy width, done pulse position and final HI/LO.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [63:0] e;
        int busy_cnt, done_cnt, done_at;
        e = ref_model(o, a, b);
        start = 1'b1; op = o; RD1 = a; RD2 = b;
        @(negedge clk_in);
        start = 1'b0; RD1 = $urandom; RD2 = $urandom;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int n = 0; n < STEPS + 2; n++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin done_cnt++; done_at = n; end
            @(negedge clk_in);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        total++; if (busy_cnt != STEPS + 2) begin bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, STEPS + 2); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt); end
        total++; if (done_at != STEPS + 1) begin bad++; $display("FAIL %s_done_cycle: got %0d want %0d", name, done_at, STEPS + 1); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_after: got %b want 0", name, busy); end
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL %s_hi: got %h want %h", name, HI, exp_hi); end
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL %s_lo: got %h want %h", name, LO, exp_lo); end
    endtask

    task automatic test_directed();
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,          "mult_neg");
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,          "div_neg");
        run_op(2'd3, 32'd100,       32'd7,          "divu_small");
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000,  "mult_minmin");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF,  "div_wrap");
        run_op(2'd3, 32'h55,        32'h0,          "divu_zero");
        run_op(2'd2, 32'hFFFF_FF00, 32'h0,          "div_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), "rand");
    endtask

    task automatic test_mthi_mtlo_idle();
        logic [31:0] d;
        d = $urandom;
        mthi_we = 1'b1; RD1 = d;
        @(negedge clk_in);
        mthi_we = 1'b0;
        exp_hi = d;
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL mthi_idle: got %h want %h", HI, exp_hi); end
        d = $urandom;
        mtlo_we = 1'b1; RD1 = d;
        @(negedge clk_in);
        mtlo_we = 1'b0;
        exp_lo = d;
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL mtlo_idle: got %h want %h", LO, exp_lo); end
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL mtlo_keeps_hi: got %h want %h", HI, exp_hi); end
    endtask

    // hilo_rd from cycle 5 and MTHI from cycle 8 during a DIVU: stall until idle,
    // HI untouched while busy, MTHI lands one edge after the result.
    task automatic test_stall_mthi();
        logic [63:0] e;
        logic exp_stall;
        e = ref_model(2'd3, 32'd1000, 32'd7);
        start = 1'b1; op = 2'd3; RD1 = 32'd1000; RD2 = 32'd7;
        @(negedge clk_in);
        start = 1'b0;
        for (int n = 0; n <= STEPS + 1; n++) begin
            if (n == 5) hilo_rd = 1'b1;
            if (n == 8) begin mthi_we = 1'b1; RD1 = 32'h1234; end
            #1;
            exp_stall = (n >= 5);
            total++; if (stall !== exp_stall) begin bad++; $display("FAIL stall_c%0d: got %b want %b", n, stall, exp_stall); end
            total++; if (HI !== exp_hi) begin bad++; $display("FAIL stall_hi_hold_c%0d: got %h want %h", n, HI, exp_hi); end
            @(negedge clk_in);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", stall); end
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL stall_op_hi: got %h want %h", HI, exp_hi); end
        @(negedge clk_in);
        hilo_rd = 1'b0; mthi_we = 1'b0;
        exp_hi = 32'h1234;
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL stall_mthi_hi: got %h want %h", HI, exp_hi); end
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL stall_mthi_lo: got %h want %h", LO, exp_lo); end
    endtask

    task automatic test_flush();
        int done_seen;
        done_seen = 0;
        start = 1'b1; op = 2'd3; RD1 = $urandom; RD2 = 32'd3;
        @(negedge clk_in);
        start = 1'b0;
        for (int n = 0; n <= 40; n++) begin
            if (done === 1'b1) done_seen++;
            if (n == 10) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_busy_before: got %b want 1", busy); end
                flush = 1'b1;
            end
            if (n == 11) begin
                flush = 1'b0;
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle: got %b want 0", busy); end
            end
            @(negedge clk_in);
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL flush_no_done: got %0d want 0", done_seen); end
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL flush_hi: got %h want %h", HI, exp_hi); end
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL flush_lo: got %h want %h", LO, exp_lo); end
        start = 1'b1; flush = 1'b1; op = 2'd1;
        @(negedge clk_in);
        start = 1'b0; flush = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_start: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 2'd1; RD1 = 32'hDEAD_BEEF; RD2 = 32'h1234_5678;
        @(negedge clk_in);
        start = 1'b0;
        repeat (15) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        total++; if (HI !== 32'h0) begin bad++; $display("FAIL rstmid_hi: got %h want 0", HI); end
        total++; if (LO !== 32'h0) begin bad++; $display("FAIL rstmid_lo: got %h want 0", LO); end
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    // Second start held (stalled) while the first op runs; accepted on first idle cycle.
    task automatic test_back_to_back();
        logic [63:0] e1, e2;
        logic [31:0] a2, b2;
        int n;
        a2 = $urandom; b2 = $urandom_range(1, 1000);
        e1 = ref_model(2'd0, 32'hFFFF_0001, 32'h0000_7FFF);
        e2 = ref_model(2'd2, a2, b2);
        start = 1'b1; op = 2'd0; RD1 = 32'hFFFF_0001; RD2 = 32'h0000_7FFF;
        @(negedge clk_in);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            if (n == 5) begin start = 1'b1; op = 2'd2; RD1 = a2; RD2 = b2; #1; end
            if (n >= 5) begin
                total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall_c%0d: got %b want 1", n, stall); end
            end
            @(negedge clk_in);
            n++;
        end
        total++; if (n != STEPS + 2) begin bad++; $display("FAIL b2b_first_len: got %0d want %0d", n, STEPS + 2); end
        exp_hi = e1[63:32];
        exp_lo = e1[31:0];
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL b2b_hi1: got %h want %h", HI, exp_hi); end
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL b2b_lo1: got %h want %h", LO, exp_lo); end
        @(negedge clk_in);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
        repeat (STEPS + 2) @(negedge clk_in);
        exp_hi = e2[63:32];
        exp_lo = e2[31:0];
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
        total++; if (HI !== exp_hi) begin bad++; $display("FAIL b2b_hi2: got %h want %h", HI, exp_hi); end
        total++; if (LO !== exp_lo) begin bad++; $display("FAIL b2b_lo2: got %h want %h", LO, exp_lo); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo_idle();
        test_stall_mthi();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
